core_seq: RTL

CORE_SEQ -- requirements
Module: core_seq

---
 rtl/core_pkg.sv | 45 ++++
 rtl/core_regfile.sv | 35 +++
 rtl/core_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core_seq sequencer: opcodes, FSM states and
// instruction field positions relative to the datapath width.
package core_pkg;

  localparam int OPW  = 4;
  localparam int HDRW = 8;

  localparam logic [OPW-1:0] OP_ADD  = 4'b0000;
  localparam logic [OPW-1:0] OP_SUB  = 4'b0001;
  localparam logic [OPW-1:0] OP_AND  = 4'b0010;
  localparam logic [OPW-1:0] OP_OR   = 4'b0011;
  localparam logic [OPW-1:0] OP_XOR  = 4'b0100;
  localparam logic [OPW-1:0] OP_NOP  = 4'b0101;
  localparam logic [OPW-1:0] OP_LDI  = 4'b1000;
  localparam logic [OPW-1:0] OP_JMP  = 4'b1100;
  localparam logic [OPW-1:0] OP_JZ   = 4'b1101;
  localparam logic [OPW-1:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  // Instruction is HDRW bits wider than the datapath; opcode sits at the top.
  function automatic int op_lsb(input int dw);
    return dw + HDRW - OPW;
  endfunction

  function automatic int rd_lsb(input int dw);
    return dw;
  endfunction

  function automatic int ra_lsb(input int dw);
    return dw / 2;
  endfunction

  function automatic int rb_lsb(input int dw);
    return (dw > 0) ? 0 : 0;
  endfunction

endpackage

// File: rtl/core_regfile.sv
// NREG x DW register file: one synchronous write port, two combinational
// operand read ports and a combinational debug read port.
module core_regfile #(
  parameter  int DW   = 8,
  parameter  int NREG = 4,
  localparam int RAW  = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [RAW-1:0] waddr,
  input  logic [DW-1:0]  wdata,
  input  logic [RAW-1:0] raddr_a,
  output logic [DW-1:0]  rdata_a,
  input  logic [RAW-1:0] raddr_b,
  output logic [DW-1:0]  rdata_b,
  input  logic [RAW-1:0] dbg_addr,
  output logic [DW-1:0]  dbg_data
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/core_seq.sv
// Multi-cycle sequencer core: FETCH/DECODE/EXEC/WB loop over a simple
// register-register ALU ISA with immediate load and absolute jumps.
module core_seq
  import core_pkg::*;
#(
  parameter  int DW   = 8,
  parameter  int NREG = 4,
  parameter  int PCW  = 8,
  localparam int RAW  = $clog2(NREG),
  localparam int IW   = DW + HDRW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_valid,
  input  logic [IW-1:0]  imem_data,
  output logic           busy,
  output logic           halted,
  output logic [PCW-1:0] pc,
  output logic           flag_z,
  output logic           flag_c,
  input  logic [RAW-1:0] dbg_addr,
  output logic [DW-1:0]  dbg_data
);

  localparam int OP_LSB = op_lsb(DW);
  localparam int RD_LSB = rd_lsb(DW);
  localparam int RA_LSB = ra_lsb(DW);
  localparam int RB_LSB = rb_lsb(DW);

  state_t         state;
  logic [IW-1:0]  ir;
  logic [DW-1:0]  op_a, op_b, alu_res;

  logic [OPW-1:0] op;
  logic [RAW-1:0] rd, ra, rb;
  logic [DW-1:0]  imm, rd_a, rd_b;
  logic [PCW-1:0] jmp_tgt;
  logic           unused_ir;

  assign op = ir[OP_LSB +: OPW];
  assign rd = ir[RD_LSB +: RAW];
  assign ra = ir[RA_LSB +: RAW];
  assign rb = ir[RB_LSB +: RAW];
  assign imm = ir[DW-1:0];
  assign unused_ir = ^ir;
  assign imem_addr = pc;

  generate
    if (PCW > DW) begin : g_tgt_ext
      assign jmp_tgt = {{(PCW-DW){1'b0}}, imm};
    end else begin : g_tgt_trunc
      assign jmp_tgt = imm[PCW-1:0];
    end
  endgenerate

  logic [DW:0]   wide;
  logic [DW-1:0] alu_next;
  logic          c_next;
  logic          is_alu;

  always_comb begin
    wide     = '0;
    alu_next = '0;
    c_next   = flag_c;
    is_alu   = 1'b1;
    case (op)
      OP_ADD: begin
        wide     = {1'b0, op_a} + {1'b0, op_b};
        alu_next = wide[DW-1:0];
        c_next   = wide[DW];
      end
      OP_SUB: begin
        wide     = {1'b0, op_a} - {1'b0, op_b};
        alu_next = wide[DW-1:0];
        c_next   = wide[DW];
      end
      OP_AND: begin alu_next = op_a & op_b; c_next = 1'b0; end
      OP_OR:  begin alu_next = op_a | op_b; c_next = 1'b0; end
      OP_XOR: begin alu_next = op_a ^ op_b; c_next = 1'b0; end
      default: is_alu = 1'b0;
    endcase
  end

  logic          wr_en;
  logic [DW-1:0] wr_data;

  assign wr_en   = (state == ST_WB) && (is_alu || op == OP_LDI);
  assign wr_data = (op == OP_LDI) ? imm : alu_res;

  core_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wr_en),
    .waddr    (rd),
    .wdata    (wr_data),
    .raddr_a  (ra),
    .rdata_a  (rd_a),
    .raddr_b  (rb),
    .rdata_b  (rd_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Outputs are registered alongside each state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= '0;
      ir       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      alu_res  <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      imem_req <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state    <= ST_FETCH;
            pc       <= '0;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            halted   <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (imem_valid) begin
            ir       <= imem_data;
            imem_req <= 1'b0;
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          op_a  <= rd_a;
          op_b  <= rd_b;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          alu_res <= alu_next;
          if (is_alu) begin
            flag_c <= c_next;
            flag_z <= (alu_next == '0);
          end
          state <= ST_WB;
        end
        ST_WB: begin
          if (op == OP_HALT) begin
            state  <= ST_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            if (op == OP_JMP || (op == OP_JZ && flag_z)) pc <= jmp_tgt;
            else pc <= pc + PCW'(1);
            imem_req <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
